// File: rtl/spi_reg_bank_pkg.sv
// Shared address map, default ID and helpers for the SPI register bank.
// Optional error counter is enabled by defining SPI_REG_BANK_ERR_CNT_EN.
package spi_reg_bank_pkg;

    localparam int unsigned ADDR_ID        = 'h00;
    localparam int unsigned ADDR_SCRATCH   = 'h01;
    localparam int unsigned ADDR_STATUS    = 'h02;
    localparam int unsigned ADDR_IRQ_FLAGS = 'h03;
    localparam int unsigned ADDR_IRQ_MASK  = 'h04;
    localparam int unsigned ADDR_ERR_CNT   = 'h05;
    localparam int unsigned ADDR_CTRL_BASE = 'h08;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'h1C7A0001;

    localparam int unsigned ERR_CNT_W = 16;

    typedef struct packed {
        logic id;
        logic scratch;
        logic status;
        logic irq_flags;
        logic irq_mask;
        logic err_cnt;
    } dec_t;

    function automatic logic [ERR_CNT_W-1:0] sat_add_err(
        input logic [ERR_CNT_W-1:0] cnt,
        input logic [1:0]           inc
    );
        logic [ERR_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(ERR_CNT_W-1){1'b0}}, inc};
        return sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/spi_irq_ctrl.sv
// Interrupt block: rising-edge detect on sources, W1C flags, mask and a
// registered level interrupt output.
module spi_irq_ctrl
    import spi_reg_bank_pkg::*;
#(
    parameter int unsigned DSZ = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [DSZ-1:0] irq_src_i,
    input  logic           flags_wr_i,
    input  logic           mask_wr_i,
    input  logic [DSZ-1:0] wr_data_i,
    output logic [DSZ-1:0] flags_o,
    output logic [DSZ-1:0] mask_o,
    output logic           irq_o
);

    logic [DSZ-1:0] src_q;
    logic [DSZ-1:0] rise;
    logic [DSZ-1:0] flags_q, flags_d;
    logic [DSZ-1:0] mask_q, mask_d;
    logic           irq_q, irq_d;

    always_comb begin
        rise    = irq_src_i & ~src_q;
        flags_d = flags_q;
        if (flags_wr_i) begin
            flags_d = flags_q & ~wr_data_i;
        end
        // OR-ing the new edges in last lets a set override a same-cycle clear
        flags_d = flags_d | rise;
        mask_d  = mask_wr_i ? wr_data_i : mask_q;
        irq_d   = |(flags_q & mask_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q   <= '0;
            flags_q <= '0;
            mask_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            src_q   <= irq_src_i;
            flags_q <= flags_d;
            mask_q  <= mask_d;
            irq_q   <= irq_d;
        end
    end

    assign flags_o = flags_q;
    assign mask_o  = mask_q;
    assign irq_o   = irq_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI slave: decode, read mux, status sync, control
// words and an optional error counter (define SPI_REG_BANK_ERR_CNT_EN).
module spi_reg_bank
    import spi_reg_bank_pkg::*;
#(
    parameter int unsigned    ASZ      = 7,
    parameter int unsigned    DSZ      = 32,
    parameter int unsigned    NCTRL    = 4,
    parameter logic [DSZ-1:0] ID_VALUE = DSZ'(DEFAULT_ID_VALUE)
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [ASZ-1:0]       addr,
    input  logic [DSZ-1:0]       wr_data,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [DSZ-1:0]       rd_data,
    input  logic [DSZ-1:0]       status_in,
    input  logic [DSZ-1:0]       irq_src,
    output logic [NCTRL*DSZ-1:0] ctrl_out,
    output logic                 irq
);

    dec_t             dec;
    logic [NCTRL-1:0] ctrl_hit;
    logic             mapped;
    logic             read_only;

    logic [DSZ-1:0]   rd_data_q, rd_data_d;
    logic [DSZ-1:0]   scratch_q, scratch_d;
    logic [DSZ-1:0]   status_meta_q, status_sync_q;
    logic [DSZ-1:0]   ctrl_q [NCTRL];
    logic [DSZ-1:0]   ctrl_d [NCTRL];

    logic [DSZ-1:0]   irq_flags;
    logic [DSZ-1:0]   irq_mask;
    logic             irq_int;

    always_comb begin
        dec           = '0;
        dec.id        = (addr == ASZ'(ADDR_ID));
        dec.scratch   = (addr == ASZ'(ADDR_SCRATCH));
        dec.status    = (addr == ASZ'(ADDR_STATUS));
        dec.irq_flags = (addr == ASZ'(ADDR_IRQ_FLAGS));
        dec.irq_mask  = (addr == ASZ'(ADDR_IRQ_MASK));
`ifdef SPI_REG_BANK_ERR_CNT_EN
        dec.err_cnt   = (addr == ASZ'(ADDR_ERR_CNT));
`endif
        ctrl_hit = '0;
        for (int unsigned i = 0; i < NCTRL; i++) begin
            ctrl_hit[i] = (addr == ASZ'(ADDR_CTRL_BASE + i));
        end
        mapped    = (|dec) | (|ctrl_hit);
        read_only = dec.id | dec.status;
    end

`ifdef SPI_REG_BANK_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [1:0]           err_inc;

    always_comb begin
        err_inc   = 2'(rd_en & ~mapped) + 2'(wr_en & (~mapped | read_only));
        err_cnt_d = sat_add_err(err_cnt_q, err_inc);
        if (wr_en && dec.err_cnt) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`endif

    // Read mux samples current register contents, so a same-cycle write is not visible
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            if (dec.id)        rd_data_d = ID_VALUE;
            if (dec.scratch)   rd_data_d = scratch_q;
            if (dec.status)    rd_data_d = status_sync_q;
            if (dec.irq_flags) rd_data_d = irq_flags;
            if (dec.irq_mask)  rd_data_d = irq_mask;
`ifdef SPI_REG_BANK_ERR_CNT_EN
            if (dec.err_cnt)   rd_data_d = {{(DSZ-ERR_CNT_W){1'b0}}, err_cnt_q};
`endif
            for (int unsigned i = 0; i < NCTRL; i++) begin
                if (ctrl_hit[i]) rd_data_d = ctrl_q[i];
            end
        end
    end

    always_comb begin
        scratch_d = (wr_en && dec.scratch) ? wr_data : scratch_q;
        for (int unsigned i = 0; i < NCTRL; i++) begin
            ctrl_d[i] = (wr_en && ctrl_hit[i]) ? wr_data : ctrl_q[i];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_data_q     <= '0;
            scratch_q     <= '0;
            status_meta_q <= '0;
            status_sync_q <= '0;
            for (int unsigned i = 0; i < NCTRL; i++) begin
                ctrl_q[i] <= '0;
            end
        end else begin
            rd_data_q     <= rd_data_d;
            scratch_q     <= scratch_d;
            status_meta_q <= status_in;
            status_sync_q <= status_meta_q;
            for (int unsigned i = 0; i < NCTRL; i++) begin
                ctrl_q[i] <= ctrl_d[i];
            end
        end
    end

    spi_irq_ctrl #(
        .DSZ (DSZ)
    ) u_irq_ctrl (
        .clk_i      (clk),
        .rst_ni     (nreset),
        .irq_src_i  (irq_src),
        .flags_wr_i (wr_en & dec.irq_flags),
        .mask_wr_i  (wr_en & dec.irq_mask),
        .wr_data_i  (wr_data),
        .flags_o    (irq_flags),
        .mask_o     (irq_mask),
        .irq_o      (irq_int)
    );

    always_comb begin
        ctrl_out = '0;
        for (int unsigned i = 0; i < NCTRL; i++) begin
            ctrl_out[i*DSZ +: DSZ] = ctrl_q[i];
        end
    end

    assign rd_data = rd_data_q;
    assign irq     = irq_int;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed accesses with literal
// expectations plus a per-cycle comparison against a register-map model.
module tb_spi_reg_bank;

    localparam logic [31:0] ID = 32'h1C7A0001;

    logic         clk;
    logic         nreset;
    logic [6:0]   addr;
    logic [31:0]  wr_data;
    logic         wr_en;
    logic         rd_en;
    logic [31:0]  rd_data;
    logic [31:0]  status_in;
    logic [31:0]  irq_src;
    logic [127:0] ctrl_out;
    logic         irq;

    int n_tests = 0;
    int n_fail  = 0;

    spi_reg_bank #(
        .ASZ      (7),
        .DSZ      (32),
        .NCTRL    (4),
        .ID_VALUE (ID)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .addr      (addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .status_in (status_in),
        .irq_src   (irq_src),
        .ctrl_out  (ctrl_out),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register-map model: what each address holds, updated once per clock.
    logic [31:0] m_scratch, m_flags, m_mask, m_rd;
    logic [31:0] m_ctrl [4];
    logic [31:0] m_st_hist [2];
    logic [31:0] m_src_prev;
    logic [15:0] m_err;
    logic        m_irq;

    function automatic bit m_mapped(input logic [6:0] a);
`ifdef SPI_REG_BANK_ERR_CNT_EN
        if (a == 7'h05) return 1'b1;
`endif
        return (a <= 7'h04) || (a >= 7'h08 && a < 7'h0C);
    endfunction

    function automatic logic [31:0] m_read(input logic [6:0] a);
        if (a == 7'h00) return ID;
        if (a == 7'h01) return m_scratch;
        if (a == 7'h02) return m_st_hist[1];
        if (a == 7'h03) return m_flags;
        if (a == 7'h04) return m_mask;
`ifdef SPI_REG_BANK_ERR_CNT_EN
        if (a == 7'h05) return {16'h0, m_err};
`endif
        if (a >= 7'h08 && a < 7'h0C) return m_ctrl[a - 7'h08];
        return 32'h0;
    endfunction

    task automatic m_reset();
        m_scratch = 0; m_flags = 0; m_mask = 0; m_rd = 0; m_irq = 0;
        m_src_prev = 0; m_err = 0;
        m_st_hist[0] = 0; m_st_hist[1] = 0;
        for (int i = 0; i < 4; i++) m_ctrl[i] = 0;
    endtask

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_reset();
        end else begin
            logic [31:0] rise;
            int          errs;
            if (rd_en) m_rd = m_read(addr);
            m_irq = |(m_flags & m_mask);
            rise = irq_src & ~m_src_prev;
            m_src_prev = irq_src;
            errs = 0;
            if (rd_en && !m_mapped(addr)) errs++;
            if (wr_en && (!m_mapped(addr) || addr == 7'h00 || addr == 7'h02)) errs++;
            if (wr_en && addr == 7'h05) m_err = 0;
            else m_err = (int'(m_err) + errs > 65535) ? 16'hFFFF : m_err + 16'(errs);
            if (wr_en) begin
                if (addr == 7'h01) m_scratch = wr_data;
                if (addr == 7'h03) m_flags = m_flags & ~wr_data;
                if (addr == 7'h04) m_mask = wr_data;
                if (addr >= 7'h08 && addr < 7'h0C) m_ctrl[addr - 7'h08] = wr_data;
            end
            m_flags = m_flags | rise;
            m_st_hist[1] = m_st_hist[0];
            m_st_hist[0] = status_in;
            #1;
            chk("model rd_data", {96'h0, rd_data}, {96'h0, m_rd});
            chk("model ctrl_out", ctrl_out, {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
            chk("model irq", {127'h0, irq}, {127'h0, m_irq});
        end
    end

    task automatic do_write(input logic [6:0] a, input logic [31:0] d);
        addr = a; wr_data = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [6:0] a, output logic [31:0] v);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        v = rd_data;
    endtask

    task automatic do_rw(input logic [6:0] a, input logic [31:0] d, output logic [31:0] v);
        addr = a; wr_data = d; wr_en = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        v = rd_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        nreset = 1'b0; addr = '0; wr_data = '0; wr_en = 1'b0; rd_en = 1'b0;
        status_in = '0; irq_src = '0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);

        chk("reset rd_data", {96'h0, rd_data}, 128'h0);
        chk("reset ctrl_out", ctrl_out, 128'h0);
        chk("reset irq", {127'h0, irq}, 128'h0);

        do_read(7'h00, v); chk("read ID", {96'h0, v}, {96'h0, 32'h1C7A0001});
        do_read(7'h01, v); chk("scratch after reset", {96'h0, v}, 128'h0);

        do_write(7'h01, 32'hDEADBEEF);
        do_read(7'h01, v); chk("scratch readback", {96'h0, v}, {96'h0, 32'hDEADBEEF});
        do_write(7'h00, 32'h0);
        do_read(7'h00, v); chk("ID not writable", {96'h0, v}, {96'h0, 32'h1C7A0001});

        addr = 7'h0A; wr_data = 32'h12345678; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        chk("ctrl2 word", {96'h0, ctrl_out[95:64]}, {96'h0, 32'h12345678});
        chk("other ctrl words", {ctrl_out[127:96], ctrl_out[63:0]}, 128'h0);

        do_write(7'h0C, 32'hFFFFFFFF);
        do_read(7'h0C, v); chk("past last ctrl reads 0", {96'h0, v}, 128'h0);
        do_write(7'h0B, 32'hAAAA5555);
        do_read(7'h0B, v); chk("ctrl3 readback", {96'h0, v}, {96'h0, 32'hAAAA5555});

        do_write(7'h04, 32'h1);
        irq_src[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("irq after edge", {127'h0, irq}, {127'h0, 1'b1});
        do_read(7'h03, v); chk("flag bit0 set", {96'h0, v}, {96'h0, 32'h1});
        irq_src[0] = 1'b0;
        @(negedge clk);
        irq_src[0] = 1'b1;
        do_write(7'h03, 32'h1);
        do_read(7'h03, v); chk("set beats clear", {96'h0, v}, {96'h0, 32'h1});
        do_write(7'h03, 32'h1);
        @(negedge clk);
        chk("irq after W1C", {127'h0, irq}, 128'h0);
        do_read(7'h03, v); chk("flags cleared", {96'h0, v}, 128'h0);

        status_in = 32'hA5A5A5A5;
        do_read(7'h02, v); chk("status stage 1", {96'h0, v}, 128'h0);
        do_read(7'h02, v); chk("status stage 2", {96'h0, v}, 128'h0);
        do_read(7'h02, v); chk("status synced", {96'h0, v}, {96'h0, 32'hA5A5A5A5});

        do_rw(7'h01, 32'h11111111, v); chk("rd+wr old value", {96'h0, v}, {96'h0, 32'hDEADBEEF});
        do_read(7'h01, v); chk("rd+wr new value", {96'h0, v}, {96'h0, 32'h11111111});

        do_read(7'h7F, v); chk("unmapped read", {96'h0, v}, 128'h0);

`ifdef SPI_REG_BANK_ERR_CNT_EN
        do_write(7'h05, 32'h0);
        repeat (3) do_read(7'h7F, v);
        do_read(7'h05, v); chk("err count 3", {96'h0, v}, {96'h0, 32'h3});
        do_rw(7'h7E, 32'h0, v);
        do_read(7'h05, v); chk("err count rd+wr", {96'h0, v}, {96'h0, 32'h5});
        do_write(7'h05, 32'h0);
        do_read(7'h05, v); chk("err count cleared", {96'h0, v}, 128'h0);
`else
        do_read(7'h05, v); chk("0x05 unmapped", {96'h0, v}, 128'h0);
`endif

        do_read(7'h01, v);
        addr = 7'h01; wr_data = 32'hFFFFFFFF; wr_en = 1'b1;
        #2 nreset = 1'b0;
        #1;
        chk("async reset rd_data", {96'h0, rd_data}, 128'h0);
        chk("async reset ctrl_out", ctrl_out, 128'h0);
        wr_en = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        do_read(7'h01, v); chk("strobe lost in reset", {96'h0, v}, 128'h0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
